// File: rtl/module_bcd_7seg_scan_if.sv
// Digit-capture and display-drive bundle for the 3-digit seven-segment scanner.
// The master side supplies BCD digits and the strobe; the slave side drives the display.
interface module_bcd_7seg_scan_if;
    logic       LOAD;
    logic [3:0] UNIDADES;
    logic [3:0] DECENAS;
    logic [3:0] CENTENAS;
    logic [6:0] SEG;
    logic [2:0] AN;
    logic       ERROR;

    modport master (
        output LOAD, UNIDADES, DECENAS, CENTENAS,
        input  SEG, AN, ERROR
    );

    modport slave (
        input  LOAD, UNIDADES, DECENAS, CENTENAS,
        output SEG, AN, ERROR
    );
endinterface

// File: rtl/module_bcd_7seg_scan.sv
// Time-multiplexed 3-digit common-anode seven-segment driver with a dark guard
// cycle at the start of every digit slot and optional leading-zero blanking.
module module_bcd_7seg_scan #(
    parameter int unsigned REFRESH_COUNT = 100000,
    parameter bit          BLANK_ZEROS   = 1'b1
) (
    input logic CLK,
    input logic RST_N,
    module_bcd_7seg_scan_if.slave bus
);
    localparam int unsigned CW = $clog2(REFRESH_COUNT);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_COUNT - 1);

    typedef enum logic [1:0] {
        SLOT_UNITS    = 2'd0,
        SLOT_TENS     = 2'd1,
        SLOT_HUNDREDS = 2'd2
    } slot_t;

    slot_t         idx;
    logic [CW-1:0] cnt;
    logic [3:0]    u_q;
    logic [3:0]    d_q;
    logic [3:0]    c_q;
    logic [6:0]    seg_q;
    logic [2:0]    an_q;
    logic          err_q;

    logic          blank_h;
    logic          blank_t;

    // Codes above 9 render as a dash rather than a digit.
    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    always_comb begin
        blank_h = BLANK_ZEROS && (c_q == 4'd0);
        blank_t = BLANK_ZEROS && (c_q == 4'd0) && (d_q == 4'd0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt   <= '0;
            idx   <= SLOT_UNITS;
            u_q   <= '0;
            d_q   <= '0;
            c_q   <= '0;
            seg_q <= '1;
            an_q  <= '1;
            err_q <= 1'b0;
        end else begin
            if (cnt == LAST) begin
                cnt <= '0;
                case (idx)
                    SLOT_UNITS: idx <= SLOT_TENS;
                    SLOT_TENS:  idx <= SLOT_HUNDREDS;
                    default:    idx <= SLOT_UNITS;
                endcase
            end else begin
                cnt <= cnt + CW'(1);
            end

            if (bus.LOAD) begin
                u_q <= bus.UNIDADES;
                d_q <= bus.DECENAS;
                c_q <= bus.CENTENAS;
            end

            err_q <= (u_q > 4'd9) || (d_q > 4'd9) || (c_q > 4'd9);

            // Outputs come from pre-edge cnt/idx/digits, so each slot opens with one dark cycle.
            if (cnt == '0) begin
                an_q  <= '1;
                seg_q <= '1;
            end else begin
                case (idx)
                    SLOT_UNITS: begin
                        an_q  <= 3'b110;
                        seg_q <= seg_of(u_q);
                    end
                    SLOT_TENS: begin
                        an_q  <= blank_t ? 3'b111 : 3'b101;
                        seg_q <= blank_t ? 7'b1111111 : seg_of(d_q);
                    end
                    default: begin
                        an_q  <= blank_h ? 3'b111 : 3'b011;
                        seg_q <= blank_h ? 7'b1111111 : seg_of(c_q);
                    end
                endcase
            end
        end
    end

    assign bus.SEG   = seg_q;
    assign bus.AN    = an_q;
    assign bus.ERROR = err_q;
endmodule
